// File: rtl/chip8_loader.sv
`default_nettype none
// ============================================================================
// Module   : chip8_loader
// Purpose  : Serial program loader for the CHIP-8 core. Parses a framed
//            image (SYNC, LEN_H, LEN_L, payload, XOR checksum) from the UART
//            receiver, writes the payload into program memory from LOAD_BASE,
//            stalls the interpreter while loading and answers ACK/NAK.
// Revision : 1.0 - initial release
// ============================================================================
module chip8_loader #(
  parameter int         ADDR_WIDTH     = 12,
  parameter int         LOAD_BASE      = 512,
  parameter int         MAX_LEN        = 3584,
  parameter logic [7:0] SYNC_BYTE      = 8'hA5,
  parameter int         TIMEOUT_CYCLES = 1000000,
  parameter logic [7:0] ACK_BYTE       = 8'h06,
  parameter logic [7:0] NAK_BYTE       = 8'h15
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [7:0]            rx_i,
  input  logic                  rx_i_v,
  output logic                  we,
  output logic [ADDR_WIDTH-1:0] waddr,
  output logic [7:0]            d,
  output logic                  cpu_hold,
  output logic [7:0]            tx_o,
  output logic                  tx_o_v,
  input  logic                  tx_busy_i,
  output logic                  done
);

  // Inter-byte timeout counter width; it never needs to hold more than
  // TIMEOUT_CYCLES-1 because expiry is detected one step before wrap.
  localparam int                TW       = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0]     TMO_LAST = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [15:0]       LEN_MAX  = 16'(MAX_LEN);
  localparam logic [ADDR_WIDTH-1:0] BASE_ADDR = ADDR_WIDTH'(LOAD_BASE);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LEN_H = 3'd1,
    S_LEN_L = 3'd2,
    S_DATA  = 3'd3,
    S_CHK   = 3'd4,
    S_RESP  = 3'd5
  } state_e;

  state_e                state_q;
  logic [15:0]           len_q;
  logic [15:0]           idx_q;
  logic [7:0]            chk_q;
  logic [TW-1:0]         tmo_q;
  logic                  ack_q;
  logic                  we_q;
  logic [ADDR_WIDTH-1:0] waddr_q;
  logic [7:0]            d_q;
  logic                  cpu_hold_q;
  logic [7:0]            tx_o_q;
  logic                  tx_o_v_q;
  logic                  done_q;

  // Next-step values derived from the current registers and incoming byte.
  logic [15:0]           idx_d;
  logic [15:0]           len_d;
  logic [ADDR_WIDTH-1:0] waddr_d;
  logic                  in_frame_d;

  // Address arithmetic: LEN <= MAX_LEN keeps LOAD_BASE+idx inside memory,
  // so truncating idx to the address width loses nothing.
  assign idx_d      = idx_q + 16'd1;
  assign len_d      = {len_q[15:8], rx_i};
  assign waddr_d    = BASE_ADDR + idx_q[ADDR_WIDTH-1:0];
  assign in_frame_d = (state_q == S_LEN_H) || (state_q == S_LEN_L) ||
                      (state_q == S_DATA)  || (state_q == S_CHK);

  // Frame parser, write port, inter-byte timeout and response generator.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      len_q      <= 16'd0;
      idx_q      <= 16'd0;
      chk_q      <= 8'd0;
      tmo_q      <= '0;
      ack_q      <= 1'b0;
      we_q       <= 1'b0;
      waddr_q    <= '0;
      d_q        <= 8'd0;
      cpu_hold_q <= 1'b0;
      tx_o_q     <= 8'd0;
      tx_o_v_q   <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      we_q     <= 1'b0;
      tx_o_v_q <= 1'b0;
      done_q   <= 1'b0;

      // Timeout only runs inside a frame. A strobe in the expiry cycle wins
      // because the state case below only acts on strobes and overrides.
      if (in_frame_d) begin
        if (rx_i_v) begin
          tmo_q <= '0;
        end else if (tmo_q == TMO_LAST) begin
          tmo_q   <= '0;
          ack_q   <= 1'b0;
          state_q <= S_RESP;
        end else begin
          tmo_q <= tmo_q + 1'b1;
        end
      end else begin
        tmo_q <= '0;
      end

      case (state_q)
        S_IDLE: begin
          if (rx_i_v && (rx_i == SYNC_BYTE)) begin
            cpu_hold_q <= 1'b1;
            state_q    <= S_LEN_H;
          end
        end
        S_LEN_H: begin
          if (rx_i_v) begin
            len_q[15:8] <= rx_i;
            state_q     <= S_LEN_L;
          end
        end
        S_LEN_L: begin
          if (rx_i_v) begin
            len_q <= len_d;
            idx_q <= 16'd0;
            chk_q <= 8'd0;
            if (len_d > LEN_MAX) begin
              ack_q   <= 1'b0;
              state_q <= S_RESP;
            end else if (len_d == 16'd0) begin
              state_q <= S_CHK;
            end else begin
              state_q <= S_DATA;
            end
          end
        end
        S_DATA: begin
          if (rx_i_v) begin
            we_q    <= 1'b1;
            waddr_q <= waddr_d;
            d_q     <= rx_i;
            chk_q   <= chk_q ^ rx_i;
            idx_q   <= idx_d;
            if (idx_d == len_q) begin
              state_q <= S_CHK;
            end
          end
        end
        S_CHK: begin
          if (rx_i_v) begin
            ack_q   <= (rx_i == chk_q);
            state_q <= S_RESP;
          end
        end
        S_RESP: begin
          // Bytes arriving here are dropped. On NAK the hold stays set since
          // memory may already be partially overwritten.
          if (!tx_busy_i) begin
            tx_o_v_q <= 1'b1;
            tx_o_q   <= ack_q ? ACK_BYTE : NAK_BYTE;
            if (ack_q) begin
              cpu_hold_q <= 1'b0;
              done_q     <= 1'b1;
            end
            state_q <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign we       = we_q;
  assign waddr    = waddr_q;
  assign d        = d_q;
  assign cpu_hold = cpu_hold_q;
  assign tx_o     = tx_o_q;
  assign tx_o_v   = tx_o_v_q;
  assign done     = done_q;

endmodule
`default_nettype wire

// File: tb/tb_chip8_loader.sv
`default_nettype none
// ============================================================================
// Module   : tb_chip8_loader
// Purpose  : Directed self-checking bench for chip8_loader.
// Revision : 1.0 - initial release
// ============================================================================
module tb_chip8_loader;

  localparam int AW = 12;

  logic          clk;
  logic          rst_n;
  logic [7:0]    rx_i;
  logic          rx_i_v;
  logic          we;
  logic [AW-1:0] waddr;
  logic [7:0]    d;
  logic          cpu_hold;
  logic [7:0]    tx_o;
  logic          tx_o_v;
  logic          tx_busy_i;
  logic          done;

  int tests;
  int fails;
  int wr_cnt;
  int tx_cnt;
  int done_cnt;
  int wr0, tx0, dn0;
  int n;

  chip8_loader #(
    .ADDR_WIDTH    (AW),
    .LOAD_BASE     (512),
    .MAX_LEN       (3584),
    .SYNC_BYTE     (8'hA5),
    .TIMEOUT_CYCLES(100),
    .ACK_BYTE      (8'h06),
    .NAK_BYTE      (8'h15)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .rx_i     (rx_i),
    .rx_i_v   (rx_i_v),
    .we       (we),
    .waddr    (waddr),
    .d        (d),
    .cpu_hold (cpu_hold),
    .tx_o     (tx_o),
    .tx_o_v   (tx_o_v),
    .tx_busy_i(tx_busy_i),
    .done     (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Event counters sampled on the inactive edge.
  always @(negedge clk) begin
    if (we)     wr_cnt++;
    if (tx_o_v) tx_cnt++;
    if (done)   done_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] b);
    rx_i   = b;
    rx_i_v = 1'b1;
    tick();
    rx_i_v = 1'b0;
  endtask

  task automatic wait_tx(input int limit, output int cyc);
    cyc = -1;
    for (int i = 1; i <= limit; i++) begin
      tick();
      if (tx_o_v === 1'b1) begin
        cyc = i;
        break;
      end
    end
  endtask

  task automatic snap();
    wr0 = wr_cnt;
    tx0 = tx_cnt;
    dn0 = done_cnt;
  endtask

  // Sends a full 3-byte frame 12 34 56 with the given checksum, back to back.
  task automatic frame3(input logic [7:0] ck);
    send(8'hA5); send(8'h00); send(8'h03);
    send(8'h12); send(8'h34); send(8'h56);
    send(ck);
  endtask

  initial begin
    tests = 0; fails = 0;
    wr_cnt = 0; tx_cnt = 0; done_cnt = 0;
    rst_n = 1'b0; rx_i = 8'h00; rx_i_v = 1'b0; tx_busy_i = 1'b0;

    // ---------------- reset state ----------------
    #12;
    check("rst_we", {31'd0, we}, 32'd0);
    check("rst_waddr", {20'd0, waddr}, 32'd0);
    check("rst_d", {24'd0, d}, 32'd0);
    check("rst_hold", {31'd0, cpu_hold}, 32'd0);
    check("rst_tx", {24'd0, tx_o}, 32'd0);
    check("rst_txv", {31'd0, tx_o_v}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    tick(); tick();
    rst_n = 1'b1;
    tick();

    // ---------------- frame A: 12 34 56, CHK 70 ----------------
    snap();
    send(8'hA5);
    check("A_hold_set", {31'd0, cpu_hold}, 32'd1);
    send(8'h00); send(8'h03);
    check("A_no_we_len", {31'd0, we}, 32'd0);
    send(8'h12);
    check("A_we0", {31'd0, we}, 32'd1);
    check("A_addr0", {20'd0, waddr}, 32'h200);
    check("A_d0", {24'd0, d}, 32'h12);
    send(8'h34);
    check("A_we1", {31'd0, we}, 32'd1);
    check("A_addr1", {20'd0, waddr}, 32'h201);
    check("A_d1", {24'd0, d}, 32'h34);
    send(8'h56);
    check("A_we2", {31'd0, we}, 32'd1);
    check("A_addr2", {20'd0, waddr}, 32'h202);
    check("A_d2", {24'd0, d}, 32'h56);
    send(8'h70);
    check("A_we_off", {31'd0, we}, 32'd0);
    check("A_hold_chk", {31'd0, cpu_hold}, 32'd1);
    wait_tx(10, n);
    check("A_resp_lat", n, 32'd1);
    check("A_tx", {24'd0, tx_o}, 32'h06);
    check("A_done", {31'd0, done}, 32'd1);
    check("A_hold_clr", {31'd0, cpu_hold}, 32'd0);
    tick();
    check("A_txv_1cyc", {31'd0, tx_o_v}, 32'd0);
    check("A_done_1cyc", {31'd0, done}, 32'd0);
    check("A_wr_cnt", wr_cnt - wr0, 32'd3);
    check("A_tx_cnt", tx_cnt - tx0, 32'd1);

    // ---------------- bad checksum then good frame ----------------
    snap();
    frame3(8'h71);
    wait_tx(10, n);
    check("B_seen", {31'd0, n != -1}, 32'd1);
    check("B_tx", {24'd0, tx_o}, 32'h15);
    check("B_hold", {31'd0, cpu_hold}, 32'd1);
    tick();
    check("B_wr_cnt", wr_cnt - wr0, 32'd3);
    check("B_done_cnt", done_cnt - dn0, 32'd0);
    frame3(8'h70);
    wait_tx(10, n);
    check("B2_tx", {24'd0, tx_o}, 32'h06);
    check("B2_hold", {31'd0, cpu_hold}, 32'd0);
    tick();

    // ---------------- length checks ----------------
    snap();
    send(8'hA5); send(8'h0E); send(8'h01);
    wait_tx(10, n);
    check("L_big_lat", n, 32'd1);
    check("L_big_tx", {24'd0, tx_o}, 32'h15);
    check("L_big_hold", {31'd0, cpu_hold}, 32'd1);
    tick();
    send(8'hA5); send(8'h00); send(8'h00); send(8'h00);
    wait_tx(10, n);
    check("L_zero_tx", {24'd0, tx_o}, 32'h06);
    check("L_zero_hold", {31'd0, cpu_hold}, 32'd0);
    tick();
    send(8'hA5); send(8'h00); send(8'h00); send(8'h01);
    wait_tx(10, n);
    check("L_zero_bad_tx", {24'd0, tx_o}, 32'h15);
    tick();
    check("L_wr_cnt", wr_cnt - wr0, 32'd0);

    // ---------------- timeout ----------------
    snap();
    send(8'hA5); send(8'h00); send(8'h02); send(8'hAA);
    // RESP is entered 100 cycles after the last strobe; the pulse follows.
    wait_tx(200, n);
    check("T_latency", {31'd0, (n >= 100) && (n <= 101)}, 32'd1);
    check("T_tx", {24'd0, tx_o}, 32'h15);
    check("T_hold", {31'd0, cpu_hold}, 32'd1);
    tick();
    check("T_wr_cnt", wr_cnt - wr0, 32'd1);
    send(8'hA5); send(8'h00); send(8'h01); send(8'h5A);
    check("T2_addr", {20'd0, waddr}, 32'h200);
    check("T2_d", {24'd0, d}, 32'h5A);
    send(8'h5A);
    wait_tx(10, n);
    check("T2_tx", {24'd0, tx_o}, 32'h06);
    check("T2_hold", {31'd0, cpu_hold}, 32'd0);
    tick();

    // ---------------- flow control ----------------
    snap();
    tx_busy_i = 1'b1;
    send(8'hA5); send(8'h00); send(8'h01); send(8'h33); send(8'h33);
    for (int i = 0; i < 20; i++) tick();
    send(8'h77);
    for (int i = 0; i < 24; i++) tick();
    check("F_no_tx_busy", tx_cnt - tx0, 32'd0);
    check("F_wr_cnt", wr_cnt - wr0, 32'd1);
    check("F_hold_wait", {31'd0, cpu_hold}, 32'd1);
    tx_busy_i = 1'b0;
    tick();
    check("F_txv", {31'd0, tx_o_v}, 32'd1);
    check("F_tx", {24'd0, tx_o}, 32'h06);
    check("F_done", {31'd0, done}, 32'd1);
    tick(); tick();
    check("F_tx_cnt", tx_cnt - tx0, 32'd1);

    // ---------------- abort and stray bytes ----------------
    send(8'hA5); send(8'h00); send(8'h04); send(8'h11);
    check("R_we_pre", {31'd0, we}, 32'd1);
    check("R_hold_pre", {31'd0, cpu_hold}, 32'd1);
    rst_n = 1'b0;
    #1;
    check("R_we_async", {31'd0, we}, 32'd0);
    check("R_hold_async", {31'd0, cpu_hold}, 32'd0);
    check("R_txv_async", {31'd0, tx_o_v}, 32'd0);
    #2;
    rst_n = 1'b1;
    tick();
    snap();
    send(8'h22); send(8'h00); send(8'hFF); send(8'hA4);
    wait_tx(20, n);
    check("R_no_resp", n, 32'hFFFF_FFFF);
    check("R_wr_cnt", wr_cnt - wr0, 32'd0);
    check("R_tx_cnt", tx_cnt - tx0, 32'd0);
    check("R_hold", {31'd0, cpu_hold}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/chip8_loader.md
Name: chip8_loader

Overview:
- Serial program loader for the CHIP-8 core: receives a framed program image as bytes from the UART receiver and writes it into interpreter program memory starting at 0x200.
- It is the writer for the memory the interpreter fetches from.
- Holds the interpreter off (cpu_hold) while a load is in progress.
- Returns a one-byte ACK/NAK to the host through the UART transmitter.

Parameters:
- ADDR_WIDTH, 12, program memory address width
- LOAD_BASE, 512, first address written (CHIP-8 program origin)
- MAX_LEN, 3584, largest accepted payload length in bytes (LOAD_BASE + MAX_LEN <= 2^ADDR_WIDTH)
- SYNC_BYTE, 8'hA5, frame start marker
- TIMEOUT_CYCLES, 1000000, max clk cycles between bytes inside a frame
- ACK_BYTE, 8'h06, success response
- NAK_BYTE, 8'h15, failure response

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- rx_i  in  8  received byte from UART receiver
- rx_i_v  in  1  one-cycle strobe, rx_i valid
- we  out  1  program memory write enable
- waddr  out  ADDR_WIDTH  program memory write address
- d  out  8  program memory write data
- cpu_hold  out  1  high = interpreter must stay stalled
- tx_o  out  8  response byte to UART transmitter
- tx_o_v  out  1  one-cycle strobe, tx_o valid
- tx_busy_i  in  1  UART transmitter busy, tx_o_v must not be issued while high
- done  out  1  one-cycle pulse when a load completes with ACK

Behaviour:
- Frame format: SYNC_BYTE, LEN_H, LEN_L, LEN payload bytes, CHK. LEN is 16-bit big-endian. CHK is the XOR of all payload bytes; CHK is 8'h00 when LEN = 0.
- Reset state (async, rst_n low): state IDLE, we=0, waddr=0, d=0, cpu_hold=0, tx_o=0, tx_o_v=0, done=0, counters and checksum cleared.
- States: IDLE, LEN_H, LEN_L, DATA, CHK, RESP.
- IDLE:
  - rx_i_v with rx_i == SYNC_BYTE -> LEN_H and cpu_hold=1 from the next cycle.
  - Any other byte is ignored; no response.
- LEN_H: the byte is stored as len[15:8] -> LEN_L.
- LEN_L: the byte is stored as len[7:0]. Then:
  - If len > MAX_LEN -> RESP with NAK.
  - Else if len == 0 -> CHK.
  - Else -> DATA, with idx=0 and chk=0.
- DATA: on each rx_i_v:
  - The next cycle drives we=1, waddr=LOAD_BASE+idx, d=rx_i for exactly one cycle.
  - chk ^= rx_i and idx increments.
  - When idx reaches len -> CHK.
  - Write latency is 1 cycle from the strobe. Back-to-back strobes on consecutive cycles must each produce a write.
- CHK: on rx_i_v, if rx_i == chk -> RESP with ACK, else -> RESP with NAK.
- RESP:
  - Waits until tx_busy_i == 0, then drives tx_o_v=1 for one cycle with tx_o = ACK_BYTE or NAK_BYTE, then -> IDLE.
  - On ACK: cpu_hold drops to 0 in the same cycle tx_o_v is asserted, and done pulses that cycle.
  - On NAK: cpu_hold stays 1, because memory is partially overwritten. It is released only by a later ACKed load or by reset.
  - rx_i_v received while in RESP is discarded.
- Timeout:
  - In LEN_H, LEN_L, DATA and CHK, a counter counts cycles since the last rx_i_v and resets on every strobe.
  - Reaching TIMEOUT_CYCLES -> RESP with NAK.
  - The counter is idle (held at 0) in IDLE and RESP.
- A SYNC_BYTE value arriving mid-frame is treated as data, length or checksum as its position dictates; there is no resync.
- rx_i_v and timeout expiry in the same cycle: the byte wins and the counter resets.
- Reset mid-frame: the load is abandoned immediately and we deasserts asynchronously. Memory already written is left as is.
- Widths: idx and len are 16-bit. waddr = (LOAD_BASE + idx) truncated to ADDR_WIDTH. Given MAX_LEN, waddr never wraps.

Test Plan:
- Frame A5 00 03 12 34 56 CHK=70 -> writes 0x200=12, 0x201=34, 0x202=56, each we one cycle, 1 cycle after strobe; tx_o=06 pulse; done pulse; cpu_hold 1->0.
- Same payload with CHK=71 -> all three writes occur, tx_o=15, cpu_hold remains 1, done never pulses. A following valid frame then ACKs and clears cpu_hold.
- Length checks:
  - A5 0E 01 (3585) -> no writes, immediate NAK 15.
  - A5 00 00 00 -> no writes, ACK 06.
  - A5 00 00 01 -> NAK.
- Timeout: A5 00 02 AA then silence for TIMEOUT_CYCLES (bench sets 100) -> NAK 15 at cycle 100 after the last strobe; the next A5 starts a fresh frame.
- Flow control: tx_busy_i held high for 50 cycles at end of a valid frame -> tx_o_v stays 0 until the cycle after tx_busy_i falls, then a single ACK pulse. A byte strobed during the wait produces no write.
- Abort and stray bytes: rst_n pulsed low mid-DATA -> we, cpu_hold, tx_o_v go 0 asynchronously; state IDLE. Bytes 00 FF A4 sent in IDLE -> no writes, no response, cpu_hold 0.
